// File: rtl/seq_bit_source_pkg.sv
// Shared types and helpers for the serial bit source: FSM state encoding,
// default geometry, and the length-clamp rule applied when a new length is loaded.
package seq_src_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SEQ_W_DEF = 64;
   localparam int CNT_W_DEF = 7;

   // A requested length of zero, or one longer than the pattern, means "whole pattern".
   function automatic logic [31:0] clamp_len(input logic [31:0] len,
                                             input logic [31:0] seq_w);
      if (len == 32'd0 || len > seq_w) return seq_w;
      return len;
   endfunction

endpackage

// File: rtl/seq_bit_source_idx_ctr.sv
// Bit index counter for seq_bit_source. idx is the index of the bit currently
// presented on the serial output. Clear forces 0, enable advances, and at the
// terminal index the counter either wraps to 0 (loop) or parks until cleared.
module seq_src_idx_ctr
   import seq_src_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             wrap,
   input  logic [CNT_W-1:0] len,
   output logic [CNT_W-1:0] idx,
   output logic [CNT_W-1:0] nxt,
   output logic             term
);

   assign term = (idx == (len - CNT_W'(1)));

   // Next index: clear wins, then advance / wrap / park at the terminal bit.
   always_comb begin
      nxt = idx;
      if (clr) begin
         nxt = '0;
      end else if (en) begin
         if (term) nxt = wrap ? '0 : idx;
         else      nxt = idx + CNT_W'(1);
      end
   end

   // Index register.
   always_ff @(posedge clk) begin
      if (rst) idx <= '0;
      else     idx <= nxt;
   end

endmodule

// File: rtl/seq_bit_source.sv
// seq_bit_source: replays a loadable pattern MSB first, one bit per clock, on x.
// Control: load/start (accepted in IDLE or DONE), hold (stalls while running).
// Optional feature macro SEQ_LOOP_EN adds the loop input, which lets a run wrap
// from its last bit straight back to bit 0 without passing through DONE.
// The pattern register is never shifted, so a run can be replayed without reloading.
module seq_bit_source
   import seq_src_pkg::*;
#(
   parameter int               SEQ_W    = SEQ_W_DEF,
   parameter int               CNT_W    = CNT_W_DEF,
   parameter logic [SEQ_W-1:0] SEQ_INIT = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [SEQ_W-1:0] seq_in,
   input  logic [CNT_W-1:0] len_in,
   input  logic             start,
   input  logic             hold,
`ifdef SEQ_LOOP_EN
   input  logic             loop,
`endif
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] bit_idx
);

   state_t           state, state_nxt;
   logic [SEQ_W-1:0] pat_q;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] idx_q, idx_nxt;
   logic             term;
   logic             accept;
   logic             loop_s;
   logic             cnt_clr, cnt_en;
   logic [SEQ_W-1:0] pat_src, pat_sh;
   logic             x_d, x_valid_d;

`ifdef SEQ_LOOP_EN
   assign loop_s = loop;
`else
   assign loop_s = 1'b0;
`endif

   // load/start are only meaningful outside RUN
   assign accept  = (state != RUN);
   assign cnt_clr = accept;
   assign cnt_en  = (state == RUN) && !hold;

   seq_src_idx_ctr #(
      .CNT_W (CNT_W)
   ) u_idx (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .wrap (loop_s),
      .len  (len_q),
      .idx  (idx_q),
      .nxt  (idx_nxt),
      .term (term)
   );

   // Pattern and clamped length capture; a load coinciding with start feeds that run.
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q <= SEQ_INIT;
         len_q <= CNT_W'(SEQ_W);
      end else if (load && accept) begin
         pat_q <= seq_in;
         len_q <= CNT_W'(clamp_len(32'(len_in), 32'(SEQ_W)));
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (!hold && term && !loop_s) state_nxt = DONE;
         end
         default: begin
            state_nxt = start ? RUN : IDLE;
         end
      endcase
   end

   // Output decode: select the bit that goes on x after this edge.
   always_comb begin
      pat_src   = (accept && load) ? seq_in : pat_q;
      pat_sh    = pat_src << idx_nxt;
      x_valid_d = 1'b0;
      case (state)
         RUN:     x_valid_d = !hold && (!term || loop_s);
         default: x_valid_d = start;
      endcase
      x_d = x_valid_d ? pat_sh[SEQ_W-1] : x;
   end

   // Serial output registers; x holds its last value while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         x       <= 1'b0;
         x_valid <= 1'b0;
      end else begin
         x       <= x_d;
         x_valid <= x_valid_d;
      end
   end

   assign busy    = (state == RUN);
   assign done    = (state == DONE);
   assign bit_idx = idx_q;

endmodule
